// File: rtl/lipsi_run_ctrl.sv
// Program-lifecycle sequencer for the lipsi core: streams a program into
// instruction memory, pulses the core reset, then runs, single-steps or halts it.
module lipsi_run_ctrl #(
  parameter int         RST_CYCLES  = 4,
  parameter int         MAX_CYCLES  = 0,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic        core_halted,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [7:0]  imem_wdata,
  output logic        core_en,
  output logic        core_rst,
  output logic [2:0]  state,
  output logic [8:0]  load_count,
  output logic [15:0] cycle_count,
  output logic        done,
  output logic        err
);

  // Handshake: a byte moves when in_valid && in_ready in the same cycle; in_ready
  // is a registered flag that is high only while loading, and the memory write is
  // issued combinationally in that same cycle.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RSTC   = 3'd2,
    S_RUN    = 3'd3,
    S_STEP   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [3:0]  RST_LAST  = 4'(RST_CYCLES - 1);
  localparam logic [15:0] MAX_LIMIT = 16'(MAX_CYCLES);

  state_t      cur_q, nxt;
  logic [8:0]  load_cnt_d;
  logic [15:0] cyc_d, cyc_inc;
  logic        done_d, err_d;
  logic [3:0]  rst_cnt_q, rst_cnt_d;
  logic        xfer;
  logic [8:0]  load_base;

  // A load_start that coincides with a transfer restarts the count, so that byte lands at address 0.
  assign xfer       = in_valid && in_ready;
  assign load_base  = load_start ? 9'd0 : load_count;
  assign imem_we    = xfer;
  assign imem_addr  = load_base[7:0];
  assign imem_wdata = in_data;
  assign state      = cur_q;
  assign cyc_inc    = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;

  always_comb begin
    nxt        = cur_q;
    load_cnt_d = load_count;
    cyc_d      = cycle_count;
    done_d     = done;
    err_d      = err;
    rst_cnt_d  = rst_cnt_q;
    case (cur_q)
      S_IDLE: begin
        if (load_start) begin
          nxt = S_LOAD; load_cnt_d = 9'd0; err_d = 1'b0; done_d = 1'b0;
        end else if (halt_req) begin
          nxt = S_IDLE;
        end else if (run_req) begin
          nxt = S_RUN; done_d = 1'b0;
        end else if (step_req) begin
          nxt = S_STEP; done_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          load_cnt_d = 9'd0; err_d = 1'b0;
        end
        if (xfer) begin
          load_cnt_d = load_base + 9'd1;
          if (in_data == HALT_OPCODE || load_base == 9'd255) begin
            nxt = S_RSTC; rst_cnt_d = RST_LAST; cyc_d = 16'd0; done_d = 1'b0;
          end
        end
      end
      S_RSTC: begin
        cyc_d  = 16'd0;
        done_d = 1'b0;
        if (rst_cnt_q == 4'd0) nxt = S_IDLE;
        else rst_cnt_d = rst_cnt_q - 4'd1;
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        if (core_halted) begin
          nxt = S_HALTED; done_d = 1'b1;
        end else if (halt_req) begin
          nxt = S_HALTED;
        end else if (MAX_CYCLES != 0 && cyc_inc >= MAX_LIMIT) begin
          nxt = S_HALTED; err_d = 1'b1;
        end
      end
      S_STEP: begin
        cyc_d  = cyc_inc;
        nxt    = S_HALTED;
        done_d = core_halted;
      end
      S_HALTED: begin
        if (load_start) begin
          nxt = S_LOAD; load_cnt_d = 9'd0; err_d = 1'b0; done_d = 1'b0;
        end else if (run_req) begin
          // A finished program must be re-reset before it can run again.
          if (done) begin
            nxt = S_RSTC; rst_cnt_d = RST_LAST; cyc_d = 16'd0; done_d = 1'b0;
          end else begin
            nxt = S_RUN;
          end
        end else if (step_req && !done) begin
          nxt = S_STEP;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q       <= S_IDLE;
      load_count  <= 9'd0;
      cycle_count <= 16'd0;
      done        <= 1'b0;
      err         <= 1'b0;
      rst_cnt_q   <= 4'd0;
      in_ready    <= 1'b0;
      core_en     <= 1'b0;
      core_rst    <= 1'b0;
    end else begin
      cur_q       <= nxt;
      load_count  <= load_cnt_d;
      cycle_count <= cyc_d;
      done        <= done_d;
      err         <= err_d;
      rst_cnt_q   <= rst_cnt_d;
      in_ready    <= (nxt == S_LOAD);
      core_en     <= (nxt == S_RUN) || (nxt == S_STEP);
      core_rst    <= (nxt == S_RSTC);
    end
  end

endmodule

// File: tb/tb_lipsi_run_ctrl.sv
// Directed bench for lipsi_run_ctrl: a default instance plus a MAX_CYCLES=10 instance on shared stimulus.
module tb_lipsi_run_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_start = 1'b0, in_valid = 1'b0, run_req = 1'b0, step_req = 1'b0;
  logic        halt_req = 1'b0, core_halted = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        in_ready, imem_we, core_en, core_rst, done, err;
  logic [7:0]  imem_addr, imem_wdata;
  logic [2:0]  state;
  logic [8:0]  load_count;
  logic [15:0] cycle_count;

  logic        m_in_ready, m_imem_we, m_core_en, m_core_rst, m_done, m_err;
  logic [7:0]  m_imem_addr, m_imem_wdata;
  logic [2:0]  m_state;
  logic [8:0]  m_load_count;
  logic [15:0] m_cycle_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lipsi_run_ctrl dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .core_halted(core_halted), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_en(core_en),
    .core_rst(core_rst), .state(state), .load_count(load_count),
    .cycle_count(cycle_count), .done(done), .err(err)
  );

  lipsi_run_ctrl #(.MAX_CYCLES(10)) dut_max (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(m_in_ready), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .core_halted(core_halted), .imem_we(m_imem_we),
    .imem_addr(m_imem_addr), .imem_wdata(m_imem_wdata), .core_en(m_core_en),
    .core_rst(m_core_rst), .state(m_state), .load_count(m_load_count),
    .cycle_count(m_cycle_count), .done(m_done), .err(m_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load_start = 0; in_valid = 0; run_req = 0; step_req = 0; halt_req = 0;
    core_halted = 0; in_data = 8'h00;
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    load_start = 0; in_valid = 1; run_req = 0; step_req = 0; halt_req = 0;
    reset_n = 0;
    #1;
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
    n_vec++; if ({in_ready, imem_we, core_en, core_rst, done, err} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 000000", {in_ready, imem_we, core_en, core_rst, done, err}); end
    n_vec++; if (load_count !== 9'd0 || cycle_count !== 16'd0) begin
      n_err++; $display("FAIL reset_counts got %0d/%0d want 0/0", load_count, cycle_count); end
    in_valid = 0;
    do_reset();
  endtask

  task automatic test_load4();
    logic [7:0] prog [4];
    int rst_hi;
    prog[0] = 8'hC7; prog[1] = 8'h0A; prog[2] = 8'h81; prog[3] = 8'hFF;
    load_start = 1; tick(); load_start = 0;
    n_vec++; if (state !== 3'd1 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL load4_enter got state=%0d rdy=%b want 1/1", state, in_ready); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = prog[i];
      #1;
      n_vec++; if (imem_we !== 1'b1 || imem_addr !== 8'(i) || imem_wdata !== prog[i]) begin
        n_err++; $display("FAIL load4_write%0d got we=%b a=%h d=%h want 1/%h/%h", i, imem_we, imem_addr, imem_wdata, 8'(i), prog[i]); end
      tick();
    end
    in_data = 8'h55;
    #1;
    n_vec++; if (state !== 3'd2 || load_count !== 9'd4 || imem_we !== 1'b0) begin
      n_err++; $display("FAIL load4_exit got st=%0d cnt=%0d we=%b want 2/4/0", state, load_count, imem_we); end
    rst_hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (!core_rst) break;
      rst_hi++;
      n_vec++; if (core_en !== 1'b0) begin n_err++; $display("FAIL load4_core_en_in_rst got %b want 0", core_en); end
      tick();
    end
    in_valid = 0;
    n_vec++; if (rst_hi !== 4) begin n_err++; $display("FAIL load4_rst_len got %0d want 4", rst_hi); end
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL load4_idle got %0d want 0", state); end
  endtask

  task automatic test_load256();
    int writes;
    int waited;
    writes = 0;
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1; in_data = 8'h01;
      #1;
      if (imem_we) writes++;
      if (i == 255) begin
        n_vec++; if (imem_we !== 1'b1 || imem_addr !== 8'd255) begin
          n_err++; $display("FAIL load256_last got we=%b a=%0d want 1/255", imem_we, imem_addr); end
      end
      tick();
    end
    #1;
    n_vec++; if (writes !== 256) begin n_err++; $display("FAIL load256_writes got %0d want 256", writes); end
    n_vec++; if (load_count !== 9'd256 || in_ready !== 1'b0 || state !== 3'd2) begin
      n_err++; $display("FAIL load256_exit got cnt=%0d rdy=%b st=%0d want 256/0/2", load_count, in_ready, state); end
    in_valid = 0;
    waited = 0;
    while (state !== 3'd0 && waited < 20) begin tick(); waited++; end
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL load256_timeout got state %0d want 0", state); end
  endtask

  task automatic test_run_halted();
    do_reset();
    run_req = 1; tick(); run_req = 0;
    n_vec++; if (state !== 3'd3 || core_en !== 1'b1) begin
      n_err++; $display("FAIL run_enter got st=%0d en=%b want 3/1", state, core_en); end
    for (int i = 0; i < 19; i++) tick();
    core_halted = 1; tick(); core_halted = 0;
    n_vec++; if (state !== 3'd5 || done !== 1'b1 || cycle_count !== 16'd20 || core_en !== 1'b0) begin
      n_err++; $display("FAIL run_halted got st=%0d done=%b cyc=%0d en=%b want 5/1/20/0", state, done, cycle_count, core_en); end
    step_req = 1; tick(); step_req = 0;
    n_vec++; if (state !== 3'd5 || core_en !== 1'b0) begin
      n_err++; $display("FAIL step_when_done got st=%0d en=%b want 5/0", state, core_en); end
    run_req = 1; tick(); run_req = 0;
    n_vec++; if (state !== 3'd2 || core_rst !== 1'b1 || done !== 1'b0 || cycle_count !== 16'd0) begin
      n_err++; $display("FAIL rerun_reset got st=%0d rst=%b done=%b cyc=%0d want 2/1/0/0", state, core_rst, done, cycle_count); end
  endtask

  task automatic test_timeout();
    int ticks;
    do_reset();
    run_req = 1; tick(); run_req = 0;
    ticks = 0;
    while (m_state !== 3'd5 && ticks < 50) begin tick(); ticks++; end
    n_vec++; if (ticks !== 10) begin n_err++; $display("FAIL timeout_len got %0d want 10", ticks); end
    n_vec++; if (m_err !== 1'b1 || m_done !== 1'b0 || m_cycle_count !== 16'd10 || m_core_en !== 1'b0) begin
      n_err++; $display("FAIL timeout_flags got err=%b done=%b cyc=%0d en=%b want 1/0/10/0", m_err, m_done, m_cycle_count, m_core_en); end
    n_vec++; if (state !== 3'd3 || err !== 1'b0) begin
      n_err++; $display("FAIL unbounded_still_run got st=%0d err=%b want 3/0", state, err); end
    run_req = 1; tick(); run_req = 0;
    n_vec++; if (m_state !== 3'd3 || m_err !== 1'b1 || m_core_en !== 1'b1) begin
      n_err++; $display("FAIL timeout_resume got st=%0d err=%b en=%b want 3/1/1", m_state, m_err, m_core_en); end
  endtask

  task automatic test_step();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step_req = 1; tick(); step_req = 0;
      n_vec++; if (state !== 3'd4 || core_en !== 1'b1) begin
        n_err++; $display("FAIL step%0d_active got st=%0d en=%b want 4/1", k, state, core_en); end
      tick();
      n_vec++; if (state !== 3'd5 || core_en !== 1'b0 || cycle_count !== 16'(k + 1)) begin
        n_err++; $display("FAIL step%0d_done got st=%0d en=%b cyc=%0d want 5/0/%0d", k, state, core_en, cycle_count, k + 1); end
      tick(); tick();
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    load_start = 1; tick(); load_start = 0;
    in_valid = 1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33;
    reset_n = 0;
    #1;
    n_vec++; if (state !== 3'd0 || imem_we !== 1'b0 || in_ready !== 1'b0 || load_count !== 9'd0) begin
      n_err++; $display("FAIL midload_reset got st=%0d we=%b rdy=%b cnt=%0d want 0/0/0/0", state, imem_we, in_ready, load_count); end
    tick();
    reset_n = 1;
    tick();
    n_vec++; if (state !== 3'd0 || imem_we !== 1'b0) begin
      n_err++; $display("FAIL midload_after got st=%0d we=%b want 0/0", state, imem_we); end
    in_valid = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_req = 1; tick(); run_req = 0;
    tick(); tick();
    halt_req = 1; core_halted = 1; tick(); halt_req = 0; core_halted = 0;
    n_vec++; if (state !== 3'd5 || done !== 1'b1) begin
      n_err++; $display("FAIL halt_and_halted got st=%0d done=%b want 5/1", state, done); end
    do_reset();
    run_req = 1; tick(); run_req = 0;
    tick(); tick();
    halt_req = 1; tick(); halt_req = 0;
    n_vec++; if (state !== 3'd5 || done !== 1'b0 || cycle_count !== 16'd3) begin
      n_err++; $display("FAIL user_halt got st=%0d done=%b cyc=%0d want 5/0/3", state, done, cycle_count); end
    run_req = 1; tick(); run_req = 0; tick();
    n_vec++; if (state !== 3'd3 || cycle_count !== 16'd4) begin
      n_err++; $display("FAIL resume got st=%0d cyc=%0d want 3/4", state, cycle_count); end
    do_reset();
    load_start = 1; run_req = 1; tick(); load_start = 0; run_req = 0;
    n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL prio_load got %0d want 1", state); end
    in_valid = 1; in_data = 8'hAA; tick();
    load_start = 1; in_data = 8'hBB;
    #1;
    n_vec++; if (imem_we !== 1'b1 || imem_addr !== 8'd0) begin
      n_err++; $display("FAIL restart_addr got we=%b a=%0d want 1/0", imem_we, imem_addr); end
    tick(); load_start = 0; in_valid = 0;
    n_vec++; if (load_count !== 9'd1 || state !== 3'd1) begin
      n_err++; $display("FAIL restart_count got cnt=%0d st=%0d want 1/1", load_count, state); end
  endtask

  initial begin
    test_reset();
    test_load4();
    test_load256();
    test_run_halted();
    test_timeout();
    test_step();
    test_reset_mid_load();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lipsi_run_ctrl.md
Name: lipsi_run_ctrl

Overview:
- Sequencer that owns the lipsi core's program lifecycle: streams a program into instruction memory, resets the core, then runs it free, single-steps it, or halts it.
- Sits between the board-level byte source (switches/UART receiver) and the core.
- Drives the core through a clock-enable and a synchronous core reset.
- Reports a run-state code and a cycle count for the seven-segment display.

Parameters:
- RST_CYCLES, 4, cycles core_rst is held high after a load or on restart (1..15).
- MAX_CYCLES, 0, run-cycle budget before a timeout error; 0 = unbounded.
- HALT_OPCODE, 8'hFF, program terminator and halt opcode.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse: begin program load.
- in_valid  in  1  input byte valid.
- in_data  in  8  program byte.
- in_ready  out  1  controller accepts a byte; a transfer happens when in_valid && in_ready.
- run_req  in  1  pulse: free-run.
- step_req  in  1  pulse: single core cycle.
- halt_req  in  1  pulse: stop the core.
- core_halted  in  1  core is fetching HALT_OPCODE or pc==255.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  8  write address.
- imem_wdata  out  8  write data.
- core_en  out  1  core clock-enable.
- core_rst  out  1  synchronous core reset.
- state  out  3  0 IDLE, 1 LOAD, 2 RSTC, 3 RUN, 4 STEP, 5 HALTED.
- load_count  out  9  bytes written by the last load (0..256).
- cycle_count  out  16  core_en-high cycles since the last core reset; saturates at 16'hFFFF.
- done  out  1  core reached halt by itself (sticky until the next load, run or step).
- err  out  1  timeout or empty load (sticky until the next load_start).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; all outputs 0; load_count=0; cycle_count=0.
  - Memory contents are untouched; the core is not reset by this block.
  - Reset during LOAD abandons the load with no further writes.
- Outputs: registered, except imem_we/addr/wdata, which are combinational from the accepted transfer. The write lands in the same cycle as the handshake.
- IDLE:
  - load_start -> LOAD: load_count:=0, err:=0.
  - run_req -> RUN.
  - step_req -> STEP.
  - Priority when several requests coincide: load_start > halt_req > run_req > step_req.
- LOAD:
  - in_ready=1.
  - Each transfer: imem_addr=load_count[7:0], imem_wdata=in_data, imem_we=1, load_count+1.
  - Exit after the transfer whose byte==HALT_OPCODE (the terminator is written), or after the transfer that makes load_count 256.
  - On exit -> RSTC. If load_count==0 at exit (impossible by construction), the empty-load err path is reserved.
  - run/step/halt requests are ignored in LOAD.
  - load_start in LOAD restarts the count at 0.
- RSTC:
  - core_rst=1, core_en=0 for exactly RST_CYCLES cycles.
  - cycle_count:=0, done:=0.
  - Then -> IDLE.
- RUN:
  - core_en=1 every cycle; cycle_count increments.
  - core_halted=1 -> HALTED with done=1. core_en drops in the cycle after core_halted is sampled.
  - halt_req -> HALTED with done=0.
  - If both arrive in the same cycle, core_halted wins: done=1.
  - MAX_CYCLES!=0 and cycle_count reaches MAX_CYCLES -> HALTED with err=1.
  - load_start in RUN is ignored; a load requires halting first.
- STEP:
  - core_en=1 for exactly one cycle; cycle_count+1.
  - Then -> HALTED; done=1 if core_halted is sampled in that cycle.
- HALTED:
  - core_en=0.
  - load_start -> LOAD.
  - run_req / step_req with done=0 -> RUN / STEP (resume, no core reset).
  - run_req with done=1 -> RSTC, then IDLE; the user issues run again.
  - step_req with done=1 is ignored.
- Counters:
  - load_count is 9-bit; addr wraps never occur because the load ends at 256.
  - cycle_count saturates rather than wrapping.

Test Plan:
- Load [C7,0A,81,FF], in_valid held high -> 4 writes at addr 0..3 on 4 consecutive cycles, load_count=4, core_rst high exactly 4 cycles, state returns to 0.
- Load 256 bytes of 8'h01 -> last write addr=255, load_count=256, in_ready=0 after the 256th transfer, state=RSTC.
- run_req, then raise core_halted at cycle 20 of RUN -> state=5, done=1, cycle_count=20, core_en low the next cycle.
- MAX_CYCLES=10, run_req with core_halted held 0 -> after 10 enabled cycles state=5, err=1, done=0. run_req then resumes with err still 1.
- Three step_req pulses, each separated by idle cycles -> three single-cycle core_en pulses, cycle_count=3, state=5 after each.
- Drop reset_n mid-load after 2 bytes with in_valid still high -> outputs 0 immediately, no further imem_we, state=0. Same cycle halt_req+core_halted in RUN -> done=1.
